// File: rtl/inband_pkg.sv
// inband_pkg: shared in-band packet definitions (header fields, packet size, timestamp "now").
package inband_pkg;
  localparam int PKT_WORDS_DEF = 128;
  localparam int HDR_PAYLOAD_LSB = 2;
  localparam int HDR_PAYLOAD_MSB = 8;
  localparam int HDR_MF_FLAG = 25;
  localparam int HDR_RSSI_FLAG = 26;
  localparam int HDR_ENDOFBURST = 27;
  localparam int HDR_STARTOFBURST = 28;
  localparam logic [31:0] TS_NOW = 32'hFFFF_FFFF;
  typedef logic [31:0] word_t;
  function automatic logic [HDR_PAYLOAD_MSB-HDR_PAYLOAD_LSB:0] hdr_payload(input word_t h);
    return h[HDR_PAYLOAD_MSB:HDR_PAYLOAD_LSB];
  endfunction
endpackage

// File: rtl/chan_pkt_ram.sv
// chan_pkt_ram: simple dual-port packet RAM, synchronous write, asynchronous show-ahead read.
module chan_pkt_ram
  import inband_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          tx_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  word_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output word_t         o_rdata
);
  word_t r_mem [2**AW];
  always_ff @(posedge tx_clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/chan_packet_fifo.sv
// chan_packet_fifo: packet-slot buffer between the USB demux and the TX sample reader.
// Define CHAN_PKT_DROP_CNT_EN to add the saturating drop_count output.
module chan_packet_fifo
  import inband_pkg::*;
#(
  parameter int PKT_WORDS = PKT_WORDS_DEF,
  parameter int NUM_PKTS  = 4,
  parameter int OFS_W     = $clog2(PKT_WORDS),
  parameter int SLOT_W    = $clog2(NUM_PKTS)
) (
  input  logic              tx_clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       wr_data,
  input  logic              wr_en,
  output logic              wr_ready,
  output logic              overrun,
  output logic [31:0]       fifodata,
  output logic              pkt_waiting,
  input  logic              rdreq,
  input  logic              skip,
`ifdef CHAN_PKT_DROP_CNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic [SLOT_W:0]   pkt_count
);
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(PKT_WORDS - 1);
  localparam logic [SLOT_W:0]  FULL     = (SLOT_W+1)'(NUM_PKTS);
  logic [OFS_W-1:0]  r_wr_ofs, r_rd_ofs;
  logic [SLOT_W-1:0] r_wr_slot, r_rd_slot;
  logic [SLOT_W:0]   r_count;
  logic              r_dropping;
  logic w_first, w_last, w_full, w_drop, w_wr, w_commit, w_skip, w_clr;
  always_comb begin
    w_first  = r_wr_ofs == '0;
    w_last   = r_wr_ofs == LAST_OFS;
    w_full   = r_count == FULL;
    // the accept/drop decision for a whole packet is taken at its first word
    w_drop   = w_first ? w_full : r_dropping;
    w_wr     = wr_en && !w_drop;
    w_commit = w_wr && w_last;
    w_skip   = skip && r_count != '0;
    w_clr    = reset || flush;
  end
  assign overrun     = wr_en && w_first && w_full;
  assign wr_ready    = !w_full;
  assign pkt_waiting = (r_count - (SLOT_W+1)'(w_skip)) != '0;
  assign pkt_count   = r_count;
  always_ff @(posedge tx_clock) begin
    if (w_clr) begin
      r_wr_ofs   <= '0;
      r_wr_slot  <= '0;
      r_rd_slot  <= '0;
      r_rd_ofs   <= '0;
      r_count    <= '0;
      r_dropping <= 1'b0;
    end else begin
      if (wr_en) begin
        r_wr_ofs   <= r_wr_ofs + OFS_W'(1);
        r_dropping <= w_drop && !w_last;
      end
      if (w_commit) r_wr_slot <= r_wr_slot + SLOT_W'(1);
      r_count <= r_count + (SLOT_W+1)'(w_commit) - (SLOT_W+1)'(w_skip);
      if (w_skip) begin
        r_rd_slot <= r_rd_slot + SLOT_W'(1);
        r_rd_ofs  <= '0;
      end else if (rdreq && r_rd_ofs != LAST_OFS) begin
        r_rd_ofs <= r_rd_ofs + OFS_W'(1);
      end
    end
  end
`ifdef CHAN_PKT_DROP_CNT_EN
  logic [15:0] r_drop_count;
  always_ff @(posedge tx_clock) begin
    if (w_clr) r_drop_count <= '0;
    else if (overrun && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end
  assign drop_count = r_drop_count;
`endif
  chan_pkt_ram #(.AW(SLOT_W + OFS_W)) u_ram (
    .tx_clock (tx_clock),
    .i_we     (w_wr),
    .i_waddr  ({r_wr_slot, r_wr_ofs}),
    .i_wdata  (wr_data),
    .i_raddr  ({r_rd_slot, r_rd_ofs}),
    .o_rdata  (fifodata)
  );
endmodule

// File: tb/tb_chan_packet_fifo.sv
// tb_chan_packet_fifo: directed sequences plus random traffic against a packet-queue reference model.
module tb_chan_packet_fifo;
  localparam int PW = 128;
  localparam int NP = 4;
  logic tx_clock = 1'b0, reset = 1'b0, flush = 1'b0, wr_en = 1'b0, rdreq = 1'b0, skip = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, overrun, pkt_waiting;
  logic [31:0] fifodata;
  logic [2:0] pkt_count;
`ifdef CHAN_PKT_DROP_CNT_EN
  logic [15:0] drop_count;
  int m_drops = 0;
`endif
  int n_chk = 0, n_pass = 0, ovr_seen = 0;
  int unsigned mq[$];
  int m_wofs = 0, m_rofs = 0, m_seed = 0;
  bit m_drop = 1'b0;
  always #5 tx_clock = ~tx_clock;
  chan_packet_fifo dut (
    .tx_clock(tx_clock), .reset(reset), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .wr_ready(wr_ready), .overrun(overrun), .fifodata(fifodata), .pkt_waiting(pkt_waiting),
    .rdreq(rdreq), .skip(skip),
`ifdef CHAN_PKT_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .pkt_count(pkt_count)
  );
  function automatic logic [31:0] word(input int s, input int k);
    return {s[15:0], k[15:0]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  // one clock: drive, check combinational outputs against the model, clock, update the model
  task automatic cyc(input bit we, input bit rq, input bit sk, input bit fl, input bit rs);
    int pre;
    bit skv, ovr;
    pre = mq.size();
    skv = sk && pre > 0;
    wr_en = we; rdreq = rq; skip = sk; flush = fl; reset = rs;
    wr_data = word(m_seed, m_wofs);
    #1;
    ovr = we && m_wofs == 0 && pre == NP;
    chk("overrun", 32'(overrun), 32'(ovr));
    chk("pkt_waiting", 32'(pkt_waiting), 32'((pre - int'(skv)) != 0));
    chk("wr_ready", 32'(wr_ready), 32'(pre < NP));
    chk("pkt_count", 32'(pkt_count), 32'(pre));
    if (pre > 0) chk("fifodata", fifodata, word(int'(mq[0]), m_rofs));
`ifdef CHAN_PKT_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    if (ovr) ovr_seen++;
    @(posedge tx_clock);
    if (rs || fl) begin
      mq.delete();
      if (m_wofs != 0) m_seed++;
      m_wofs = 0; m_rofs = 0; m_drop = 1'b0;
`ifdef CHAN_PKT_DROP_CNT_EN
      m_drops = 0;
`endif
    end else begin
`ifdef CHAN_PKT_DROP_CNT_EN
      if (ovr && m_drops < 65535) m_drops++;
`endif
      if (skv) begin
        void'(mq.pop_front());
        m_rofs = 0;
      end else if (rq && m_rofs < PW - 1) m_rofs++;
      if (we) begin
        if (m_wofs == 0) m_drop = (pre == NP);
        if (m_wofs == PW - 1 && !m_drop) mq.push_back(m_seed);
        m_wofs = (m_wofs + 1) % PW;
        if (m_wofs == 0) m_seed++;
      end
    end
    #1;
    wr_en = 1'b0; rdreq = 1'b0; skip = 1'b0; flush = 1'b0; reset = 1'b0;
    #1;
  endtask
  task automatic wr_pkt();
    repeat (PW) cyc(1, 0, 0, 0, 0);
  endtask
  task automatic rd_pkt();
    repeat (PW - 1) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
  endtask
  typedef struct {
    bit rq, sk, cd;
    logic [31:0] d;
    bit w;
    int c;
  } vec_t;
  vec_t tbl[4];
  initial begin
    int sa, sb;
    tbl[0] = '{rq: 0, sk: 0, cd: 1, d: 32'd0, w: 1, c: 1};
    tbl[1] = '{rq: 1, sk: 0, cd: 1, d: 32'd1, w: 1, c: 1};
    tbl[2] = '{rq: 1, sk: 0, cd: 1, d: 32'd2, w: 1, c: 1};
    tbl[3] = '{rq: 0, sk: 1, cd: 0, d: 32'd0, w: 0, c: 0};
    reset = 1'b1;
    repeat (2) @(posedge tx_clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_waiting", 32'(pkt_waiting), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    // single packet, word k = k, then reader handshake table
    wr_pkt();
    chk("t1_waiting", 32'(pkt_waiting), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, tbl[i].rq, tbl[i].sk, 0, 0);
      if (tbl[i].cd) chk("t1_fifodata", fifodata, tbl[i].d);
      chk("t1_waiting_v", 32'(pkt_waiting), 32'(tbl[i].w));
      chk("t1_count_v", 32'(pkt_count), 32'(tbl[i].c));
    end
    // overrun on a full buffer, then a packet after one release
    repeat (NP) wr_pkt();
    ovr_seen = 0;
    wr_pkt();
    chk("t2_overrun_once", 32'(ovr_seen), 32'd1);
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    chk("t2_count", 32'(pkt_count), 32'd4);
    cyc(0, 0, 1, 0, 0);
    wr_pkt();
    chk("t2_count_after", 32'(pkt_count), 32'd4);
    repeat (NP) rd_pkt();
    // commit coincident with skip
    sa = m_seed;
    repeat (2) wr_pkt();
    repeat (PW - 1) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("t3_count", 32'(pkt_count), 32'd2);
    chk("t3_header", fifodata, word(sa + 1, 0));
    // skip wins over rdreq, then release of the last packet
    cyc(0, 1, 1, 0, 0);
    chk("t4_header", fifodata, word(sa + 2, 0));
    cyc(0, 1, 1, 0, 0);
    chk("t4_count", 32'(pkt_count), 32'd0);
    chk("t4_waiting", 32'(pkt_waiting), 32'd0);
    // read offset saturates inside its slot
    sa = m_seed;
    sb = m_seed + 1;
    repeat (2) wr_pkt();
    repeat (200) cyc(0, 1, 0, 0, 0);
    chk("t5_sat", fifodata, word(sa, PW - 1));
    cyc(0, 0, 1, 0, 0);
    chk("t5_next", fifodata, word(sb, 0));
    cyc(0, 0, 1, 0, 0);
    // reset mid-packet discards it
    repeat (60) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t6_count", 32'(pkt_count), 32'd0);
    chk("t6_waiting", 32'(pkt_waiting), 32'd0);
    sa = m_seed;
    wr_pkt();
    chk("t6_new_header", fifodata, word(sa, 0));
    rd_pkt();
`ifdef CHAN_PKT_DROP_CNT_EN
    cyc(0, 0, 0, 1, 0);
    repeat (NP) wr_pkt();
    repeat (3) wr_pkt();
    chk("t7_drops", 32'(drop_count), 32'd3);
    cyc(1, 0, 0, 1, 0);
    chk("t7_drops_clr", 32'(drop_count), 32'd0);
`endif
    cyc(0, 0, 0, 1, 0);
    for (int p = 0; p < 8; p++) begin
      repeat (600) cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       (p % 2 == 0) ? $urandom_range(0, 299) == 0 : $urandom_range(0, 19) == 0,
                       $urandom_range(0, 2999) == 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
